fma16_sched: RTL

- Shares one fma16 datapath instance (multiply, add, normalize, round) between NREQ requesters.
- Each requester has a valid/ready request port and a one-deep response buffer.
- The block arbitrates round-robin, registers operands into the core, and tracks in-flight ops with a tag pipeline matched to the core's fixed latency.
- It returns each result and its flags to the requester that issued the op.

---
 rtl/fma16_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fma16_sched.sv
// fma16_sched: round-robin scheduler sharing one fixed-latency fp16 FMA core between
// NREQ requesters, with one outstanding op and a one-deep response buffer per requester.
module fma16_sched #(
    parameter int NREQ     = 2,
    parameter int CORE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic [4*NREQ-1:0]    req_ctrl,
    input  logic [2*NREQ-1:0]    req_rnd,
    output logic                 core_issue,
    output logic [15:0]          core_x,
    output logic [15:0]          core_y,
    output logic [15:0]          core_z,
    output logic [3:0]           core_ctrl,
    output logic [1:0]           core_rnd,
    input  logic [15:0]          core_result,
    input  logic [3:0]           core_flags,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [16*NREQ-1:0]   rsp_result,
    output logic [4*NREQ-1:0]    rsp_flags,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]      r_ptr;
    logic [NREQ-1:0]    r_inflight;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [16*NREQ-1:0] r_rsp_result;
    logic [4*NREQ-1:0]  r_rsp_flags;
    logic               r_issue;
    logic [PW-1:0]      r_issue_tag;
    logic [15:0]        r_x, r_y, r_z;
    logic [3:0]         r_ctrl;
    logic [1:0]         r_rnd;

    logic [NREQ-1:0]    w_eligible;
    logic [NREQ-1:0]    w_grant;
    logic               w_grant_any;
    logic [PW-1:0]      w_grant_idx;
    logic [PW-1:0]      w_scan_idx;
    logic [PW-1:0]      w_ptr_next;
    logic               w_ret_vld;
    logic [PW-1:0]      w_ret_tag;

    assign w_eligible = req_valid & ~r_inflight & ~r_rsp_valid;

    // NOTE: blocking assignments here are deliberate: the scan must see its own
    // earlier iterations so only the first eligible index past the pointer wins.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (reset_n && !w_grant_any && w_eligible[w_scan_idx]) begin
                w_grant_any         = 1'b1;
                w_grant_idx         = w_scan_idx;
                w_grant[w_scan_idx] = 1'b1;
            end
        end
    end

    assign w_ptr_next = (int'(w_grant_idx) == NREQ - 1) ? '0 : w_grant_idx + PW'(1);

    // Tag pipeline: tells us which requester owns the result on core_result.
    generate
        if (CORE_LAT == 0) begin : g_tag_comb
            assign w_ret_vld = r_issue;
            assign w_ret_tag = r_issue_tag;
        end else begin : g_tag_pipe
            logic [CORE_LAT-1:0] r_pipe_vld;
            logic [PW-1:0]       r_pipe_tag [CORE_LAT];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_pipe_vld <= '0;
                    for (int k = 0; k < CORE_LAT; k++) r_pipe_tag[k] <= '0;
                end else begin
                    r_pipe_vld[0] <= r_issue;
                    r_pipe_tag[0] <= r_issue_tag;
                    for (int k = 1; k < CORE_LAT; k++) begin
                        r_pipe_vld[k] <= r_pipe_vld[k-1];
                        r_pipe_tag[k] <= r_pipe_tag[k-1];
                    end
                end
            end

            assign w_ret_vld = r_pipe_vld[CORE_LAT-1];
            assign w_ret_tag = r_pipe_tag[CORE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: response data is cleared too so a requester never observes stale
            // results from before reset; results still in the core are dropped.
            r_ptr        <= '0;
            r_inflight   <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_issue      <= 1'b0;
            r_issue_tag  <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_ctrl       <= '0;
            r_rnd        <= '0;
        end else begin
            if (w_grant_any) r_ptr <= w_ptr_next;
            r_issue     <= w_grant_any;
            r_issue_tag <= w_grant_idx;
            r_x    <= w_grant_any ? req_x[16*w_grant_idx +: 16]  : '0;
            r_y    <= w_grant_any ? req_y[16*w_grant_idx +: 16]  : '0;
            r_z    <= w_grant_any ? req_z[16*w_grant_idx +: 16]  : '0;
            r_ctrl <= w_grant_any ? req_ctrl[4*w_grant_idx +: 4] : '0;
            r_rnd  <= w_grant_any ? req_rnd[2*w_grant_idx +: 2]  : '0;
            for (int i = 0; i < NREQ; i++) begin
                if (r_rsp_valid[i] && rsp_ready[i]) r_rsp_valid[i] <= 1'b0;
                if (w_ret_vld && int'(w_ret_tag) == i) begin
                    r_rsp_valid[i]           <= 1'b1;
                    r_rsp_result[16*i +: 16] <= core_result;
                    r_rsp_flags[4*i +: 4]    <= core_flags;
                    r_inflight[i]            <= 1'b0;
                end
                if (w_grant[i]) r_inflight[i] <= 1'b1;
            end
        end
    end

    a_no_ret_to_full: assert property (@(posedge clk) disable iff (!reset_n)
        w_ret_vld |-> !r_rsp_valid[w_ret_tag]);

    assign req_ready  = w_grant;
    assign core_issue = r_issue;
    assign core_x     = r_x;
    assign core_y     = r_y;
    assign core_z     = r_z;
    assign core_ctrl  = r_ctrl;
    assign core_rnd   = r_rnd;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign busy       = (|r_inflight) | (|r_rsp_valid);

endmodule
